// File: rtl/serial_cmd_pkg.sv
// Shared encodings for the serial command master: op codes, protocol bytes,
// FSM state enum and helpers that build header and expected echo bytes.
package serial_cmd_pkg;

   localparam logic [1:0] OP_R    = 2'd0;
   localparam logic [1:0] OP_W    = 2'd1;
   localparam logic [1:0] OP_V    = 2'd2;
   localparam logic [1:0] OP_RSVD = 2'd3;

   localparam logic [7:0] BYTE_SYNC  = 8'hFF;
   localparam logic [7:0] BYTE_ECHO  = 8'h40;  // "@"
   localparam logic [7:0] BYTE_WACK  = 8'h77;  // "w"
   localparam logic [7:0] BYTE_WDONE = 8'h57;  // "W"
   localparam logic [7:0] BYTE_R     = 8'h52;
   localparam logic [7:0] BYTE_W     = 8'h57;
   localparam logic [7:0] BYTE_V     = 8'h56;
   localparam logic [7:0] BYTE_ZERO  = 8'h30;  // "0"

   typedef enum logic [2:0] {
      IDLE, HDR, WR_DATA, WR_ACK, RD_DATA, FINISH
   } state_t;

   function automatic logic [7:0] op_byte(input logic [1:0] op);
      case (op)
         OP_R:    op_byte = BYTE_R;
         OP_W:    op_byte = BYTE_W;
         OP_V:    op_byte = BYTE_V;
         default: op_byte = 8'h00;
      endcase
   endfunction

   // Header bytes sent: V carries no address.
   function automatic logic [2:0] hdr_count(input logic [1:0] op);
      hdr_count = (op == OP_V) ? 3'd3 : 3'd7;
   endfunction

   // Echo bytes expected back: only W echoes the address digits.
   function automatic logic [2:0] echo_count(input logic [1:0] op);
      echo_count = (op == OP_W) ? 3'd7 : 3'd3;
   endfunction

   function automatic logic [7:0] hdr_byte(input logic [1:0] op, input logic [7:0] len,
                                           input logic [31:0] addr, input logic [2:0] idx);
      case (idx)
         3'd0:    hdr_byte = BYTE_SYNC;
         3'd1:    hdr_byte = len;
         3'd2:    hdr_byte = op_byte(op);
         3'd3:    hdr_byte = addr[31:24];
         3'd4:    hdr_byte = addr[23:16];
         3'd5:    hdr_byte = addr[15:8];
         3'd6:    hdr_byte = addr[7:0];
         default: hdr_byte = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] echo_byte(input logic [1:0] op, input logic [7:0] len,
                                            input logic [2:0] idx);
      case (idx)
         3'd0:    echo_byte = BYTE_ECHO;
         3'd1:    echo_byte = BYTE_ZERO + len;
         3'd2:    echo_byte = op_byte(op);
         3'd3:    echo_byte = 8'h33;
         3'd4:    echo_byte = 8'h32;
         3'd5:    echo_byte = 8'h31;
         3'd6:    echo_byte = 8'h30;
         default: echo_byte = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/serial_cmd_timer.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry combinationally once LIMIT cycles have accumulated.
module serial_cmd_timer #(
   parameter int LIMIT = 95998
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable && (cnt != CW'(LIMIT))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = enable && !clear && (cnt == CW'(LIMIT));

endmodule

// File: rtl/serial_cmd_master.sv
// Byte-serial command master (R/W/V) over a UART byte interface.
// Define ECHO_CHECK_EN to compare every echo byte and abort on mismatch.
module serial_cmd_master
   import serial_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 96000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_len,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_strobe,
   output logic [7:0]  tx_data,
   output logic        tx_strobe,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_strobe,
   output logic        busy,
   output logic        done,
   output logic        error,
   output state_t      state
);

   // Valid/ready: a transfer happens on a rising edge where both are high;
   // the master keeps cmd_ready/wr_ready registered and never drops valid data.

   // Decision is taken two cycles ahead so done lands TIMEOUT_CYCLES after the last rx byte.
   localparam int TIMER_LIMIT = (TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES - 2 : 0;

   logic [1:0]  op_q;
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic [2:0]  tx_idx;
   logic [2:0]  echo_idx;
   logic [7:0]  data_cnt;
   logic        ack_seen;
   logic [7:0]  wr_buf;
   logic        wr_have;

   logic hdr_sent, echo_done, echo_bad;
   logic timer_run, timer_clear, timer_expired;

   assign hdr_sent  = (tx_idx == hdr_count(op_q));
   assign echo_done = (echo_idx == echo_count(op_q));

`ifdef ECHO_CHECK_EN
   logic [7:0] echo_exp;
   always_comb begin
      echo_exp = echo_byte(op_q, len_q, echo_idx);
      if (state == WR_ACK) echo_exp = ack_seen ? BYTE_WDONE : BYTE_WACK;
   end
   assign echo_bad = (rx_data != echo_exp);
`else
   assign echo_bad = 1'b0;
`endif

   assign timer_run   = hdr_sent && ((state == HDR) || (state == WR_ACK) || (state == RD_DATA));
   assign timer_clear = rx_strobe || !timer_run;

   serial_cmd_timer #(.LIMIT(TIMER_LIMIT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_run),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         tx_strobe <= 1'b0;
         tx_data   <= 8'h00;
         rd_strobe <= 1'b0;
         rd_data   <= 8'h00;
         wr_ready  <= 1'b0;
         op_q      <= OP_R;
         addr_q    <= '0;
         len_q     <= '0;
         tx_idx    <= '0;
         echo_idx  <= '0;
         data_cnt  <= '0;
         ack_seen  <= 1'b0;
         wr_buf    <= '0;
         wr_have   <= 1'b0;
      end else begin
         tx_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         if (timer_expired) begin
            state    <= FINISH;
            done     <= 1'b1;
            error    <= 1'b1;
            wr_ready <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_valid && cmd_ready) begin
                     op_q      <= cmd_op;
                     addr_q    <= cmd_addr;
                     len_q     <= cmd_len;
                     tx_idx    <= '0;
                     echo_idx  <= '0;
                     data_cnt  <= '0;
                     ack_seen  <= 1'b0;
                     wr_have   <= 1'b0;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                     state     <= HDR;
                  end
               end
               HDR: begin
                  if ((len_q == 8'd0) || (op_q == OP_RSVD)) begin
                     state <= FINISH;
                     done  <= 1'b1;
                     error <= 1'b1;
                  end else if (rx_strobe && !echo_done && echo_bad) begin
                     state <= FINISH;
                     done  <= 1'b1;
                     error <= 1'b1;
                  end else begin
                     // Echoes are consumed even while the transmitter is stalled.
                     if (rx_strobe && !echo_done) echo_idx <= echo_idx + 3'd1;
                     if (!hdr_sent && tx_ready && !tx_strobe) begin
                        tx_data   <= hdr_byte(op_q, len_q, addr_q, tx_idx);
                        tx_strobe <= 1'b1;
                        tx_idx    <= tx_idx + 3'd1;
                     end
                     if (hdr_sent && echo_done) begin
                        if (op_q == OP_W) begin
                           state    <= WR_DATA;
                           wr_ready <= 1'b1;
                        end else begin
                           state <= RD_DATA;
                        end
                     end
                  end
               end
               WR_DATA: begin
                  if (!wr_have) begin
                     if (wr_valid) begin
                        wr_buf   <= wr_data;
                        wr_have  <= 1'b1;
                        wr_ready <= 1'b0;
                     end
                  end else if (tx_ready && !tx_strobe) begin
                     tx_data   <= wr_buf;
                     tx_strobe <= 1'b1;
                     wr_have   <= 1'b0;
                     ack_seen  <= 1'b0;
                     state     <= WR_ACK;
                  end
               end
               WR_ACK: begin
                  if (rx_strobe) begin
                     if (echo_bad) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        error <= 1'b1;
                     end else if (!ack_seen) begin
                        ack_seen <= 1'b1;
                     end else if (data_cnt + 8'd1 == len_q) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        error <= 1'b0;
                     end else begin
                        data_cnt <= data_cnt + 8'd1;
                        ack_seen <= 1'b0;
                        wr_ready <= 1'b1;
                        state    <= WR_DATA;
                     end
                  end
               end
               RD_DATA: begin
                  if (rx_strobe) begin
                     rd_data   <= rx_data;
                     rd_strobe <= 1'b1;
                     data_cnt  <= data_cnt + 8'd1;
                     if (data_cnt + 8'd1 == len_q) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        error <= 1'b0;
                     end
                  end
               end
               FINISH: begin
                  done      <= 1'b0;
                  error     <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/serial_cmd_master.md
SERIAL_CMD_MASTER -- requirements
Module: serial_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 96000, meaning idle-cycle limit between response bytes before abort.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock for all logic.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (0=R, 1=W, 2=V, 3=reserved), cmd_addr in 32, cmd_len in 8: the command request handshake.
REQ-005 SHALL have wr_data in 8, wr_valid in 1, wr_ready out 1: the write payload stream.
REQ-006 SHALL have rd_data out 8, rd_strobe out 1: read and version payload bytes, one-cycle strobe.
REQ-007 SHALL have tx_data out 8, tx_strobe out 1, tx_ready in 1: byte output toward the UART transmitter.
REQ-008 SHALL have rx_data in 8, rx_strobe in 1: byte input from the UART receiver.
REQ-009 SHALL have busy out 1, done out 1 (one-cycle pulse), error out 1 (valid with done).

Function
REQ-010 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready=1 only in IDLE; op/addr/len registered on acceptance.
REQ-011 SHALL use states IDLE, HDR, WR_DATA, WR_ACK, RD_DATA, FINISH.
REQ-012 SHALL in HDR emit FF, L, op byte ("R"=52h, "W"=57h, "V"=56h), then for R/W addr[31:24], [23:16], [15:8], [7:0]; V sends 3 header bytes only.
REQ-013 SHALL emit at most one tx byte per cycle, only when tx_ready=1; tx_strobe one cycle per byte.
REQ-014 SHALL treat each rx_strobe as one response byte; expected header echoes: "@", "0"+L (mod 256), op byte, and for W additionally "3","2","1","0".
REQ-015 SHALL after header echoes: R and V go to RD_DATA, passing the next L rx bytes to rd_data with rd_strobe in the cycle after rx_strobe.
REQ-016 SHALL for W: WR_DATA asserts wr_ready for one transfer, sends the byte, enters WR_ACK; WR_ACK requires echoes "w" then "W" before the next byte; after L bytes go to FINISH.
REQ-017 SHALL not send the next W payload byte before the "W" echo of the previous byte (responder holds one pending byte).
REQ-018 SHALL in FINISH pulse done for one cycle with error, then return to IDLE.
REQ-019 SHALL complete cmd_len=0 or cmd_op=3 without emitting any tx byte: done with error=1 two cycles after acceptance.
REQ-020 SHALL count idle cycles after the final header byte is sent; counter clears on rx_strobe; at TIMEOUT_CYCLES abort to FINISH with error=1.
REQ-021 SHALL ignore rx_strobe in IDLE; an rx byte arriving while tx is stalled SHALL still be consumed and counted.
REQ-022 SHALL hold busy=1 from acceptance through the done cycle inclusive.

Reset
REQ-023 SHALL on reset force IDLE; clear cmd_ready→1 after reset, tx_strobe, rd_strobe, done, error, busy, wr_ready, counters to 0; tx_data, rd_data to 00h.
REQ-024 SHALL on reset mid-command abandon it silently: no done pulse, no further tx bytes.

Configuration
REQ-025 SHALL with ECHO_CHECK_EN defined compare every echo byte to its expected value; on mismatch go to FINISH with error=1 (payload bytes not compared).
REQ-026 SHALL without ECHO_CHECK_EN only count echo bytes; error arises only from timeout, len=0, or op=3.

Structure
REQ-027 SHALL place op encodings, protocol bytes (FF, "@", "w", "W", "R", "V"), and the state enum in package serial_cmd_pkg.
REQ-028 SHALL implement the timeout counter as sub-module serial_cmd_timer (clear, enable, expired).

Verification
REQ-029 SHALL cover: R, addr 0000_1234h, len 2, model echoes "@","2","R",AAh,BBh -> tx FF 02 52 00 00 12 34; rd_data AAh then BBh; done, error=0.
REQ-030 SHALL cover: W, addr 10h, len 2, data 11h,22h -> tx FF 02 57 00 00 00 10 11 22; 22h only after "w","W" for 11h; done, error=0.
REQ-031 SHALL cover: V, len 3, echoes "@","3","V","1","1","1" -> tx FF 03 56; three rd_strobe of 31h; done, error=0.
REQ-032 SHALL cover: R len 1 with echo "!" instead of "@" -> error=1 with ECHO_CHECK_EN, normal completion without it.
REQ-033 SHALL cover: R len 4, model stops after 2 data bytes, TIMEOUT_CYCLES=50 -> done, error=1 exactly 50 cycles after the last rx_strobe.
REQ-034 SHALL cover: reset asserted during WR_ACK -> IDLE, cmd_ready=1, no done; tx_ready held 0 mid-header -> bytes resume in order.
